brick_sort_seq: RTL
===================

# brick_sort_seq

Iterative odd-even transposition (brick) sorter for one vector of 2**LOG_INPUT_NUM words. It holds the vector in an internal register `q` and applies one comparator phase per clock: even phase (pairs 0-1, 2-3, …) and odd phase (pairs 1-2, 3-4, …), alternating. A valid/ready handshake loads the vector and another returns the sorted result. It is the sequential wrapper that registers the even and odd comparator stages' `din` and feeds it back as `q`.

## Interface
Parameters:
- LOG_INPUT_NUM, 4, log2 of word count N; N = 2**LOG_INPUT_NUM, LOG_INPUT_NUM >= 1
- DATA_WIDTH, 32, bits per word
- SIGNED, 0, 1 = two's-complement compare, 0 = unsigned
- ASCENDING, 1, 1 = smallest word at index 0, 0 = largest word at index 0

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  in_data is valid
- in_ready  out  1  block can accept a vector
- in_data  in  DATA_WIDTH*N  word i at bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH]
- out_valid  out  1  out_data holds the sorted vector
- out_ready  in  1  consumer accepts out_data
- out_data  out  DATA_WIDTH*N  sorted vector, same packing as in_data; equals `q`
- busy  out  1  high in SORT state

## Operation
- FSM states: IDLE, SORT, DONE. Reset state: IDLE.
- IDLE: in_ready = 1. On in_valid: q <= in_data, phase_cnt <= 0, go to SORT.
- SORT: each cycle, q <= phase(q, phase_cnt[0]).
  - Bit 0 = 0: even phase. Bit 0 = 1: odd phase.
  - In the odd phase, words 0 and N-1 pass through unchanged.
  - phase_cnt increments each cycle. When phase_cnt == N-1, go to DONE.
- Compare-exchange on pair (lo, hi):
  - Words swap when ASCENDING=1 and lo > hi, or ASCENDING=0 and lo < hi.
  - Equal words never swap.
  - SIGNED selects a signed or unsigned `>` on the full DATA_WIDTH.
- DONE: out_valid = 1. On out_ready, leave DONE.
- in_ready = (state == IDLE) || (state == DONE && out_ready). This is a combinational path from out_ready to in_ready.
- Output handshake and a new in_valid in the same cycle: the new vector loads and the FSM goes directly to SORT.
- Output handshake with no in_valid: the FSM returns to IDLE.
- In SORT, in_valid is ignored (in_ready = 0).
- In DONE, q is frozen. out_data stays stable until the handshake.
- phase_cnt is LOG_INPUT_NUM bits wide and never wraps past N-1.

## Timing
- Reset values:
  - in_ready = 1
  - out_valid = 0
  - busy = 0
  - out_data = 0 (q cleared)
  - phase_cnt = 0
  - state = IDLE
- Reset asserted mid-SORT or in DONE aborts immediately. The vector is discarded and no out_valid follows.
- Latency:
  - The accepting edge loads q.
  - The next N edges apply phases 0..N-1.
  - out_valid rises after the N-th phase edge, i.e. N+1 edges after the load.
- Throughput without backpressure: one vector per N+1 cycles.
- busy is high for exactly N cycles per vector (fixed mode).

## Configuration
- Macro BRICK_SORT_EARLY_EXIT_EN.
- Defined:
  - Each SORT cycle records `swapped` (any pair swapped in that phase) into a 1-bit register `prev_swapped`.
  - If the current phase has no swap and prev_swapped == 0 and phase_cnt >= 1, go to DONE after this edge.
  - Two consecutive swap-free phases (one even, one odd) prove the vector is sorted.
  - Minimum latency is 2 phase edges. Maximum is unchanged (N).
  - prev_swapped is set to 1 on load and on reset.
- Not defined:
  - Exactly N phases always.
  - No swap-detection logic is synthesized.

## Test plan
- Reverse input, defaults (N=16, unsigned, ascending): load words i = 15-i → out_data words i = i. out_valid asserts N+1 edges after the load; busy is high for 16 cycles.
- SIGNED=1, LOG_INPUT_NUM=2, DATA_WIDTH=8: load {3, -1, 0, -128} (index 0 first) → {-128, -1, 0, 3}. With SIGNED=0, the same bits sort as {0, 3, 0x80, 0xFF}.
- ASCENDING=0 with duplicates {5, 5, 1, 9, 1, 9, 0, 0, …}: result is non-increasing, and the multiset of words is preserved.
- Backpressure: hold out_ready=0 for 20 cycles in DONE → out_data stable, in_ready=0. Raise out_ready together with in_valid → the new vector loads in the same cycle and busy rises on the next cycle.
- Reset mid-sort: deassert rst_n at phase 5 → all outputs take their reset values asynchronously. After release, in_ready=1, and a fresh vector sorts correctly.
- BRICK_SORT_EARLY_EXIT_EN: an already-sorted input reaches out_valid after 2 phase edges. Reverse input still takes N phases. Without the macro, the sorted input takes N phases.

Source files
------------

// File: rtl/brick_sort_seq.sv
// Iterative odd-even transposition sorter over one vector of 2**LOG_INPUT_NUM words, one comparator phase per clock.
// Latency: load edge plus N phase edges before out_valid (BRICK_SORT_EARLY_EXIT_EN: can finish after 2 phases).
// Backpressure: out_valid holds q frozen until out_ready; in_ready also rises in DONE when out_ready is high.
module brick_sort_seq #(
  parameter int LOG_INPUT_NUM = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int SIGNED        = 0,
  parameter int ASCENDING     = 1
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic [DATA_WIDTH*(2**LOG_INPUT_NUM)-1:0]   in_data,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [DATA_WIDTH*(2**LOG_INPUT_NUM)-1:0]   out_data,
  output logic                                       busy
);

  localparam int N = 2**LOG_INPUT_NUM;

  typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

  state_t                   state, state_nxt;
  logic [DATA_WIDTH-1:0]    q   [N];
  logic [DATA_WIDTH-1:0]    nxt [N];
  logic [LOG_INPUT_NUM-1:0] phase_cnt;
  logic                     load, step, last;

  // True when a is strictly greater than b under the configured number format.
  function automatic logic gt(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
    if (SIGNED != 0) return $signed(a) > $signed(b);
    else             return a > b;
  endfunction

`ifdef BRICK_SORT_EARLY_EXIT_EN
  logic swapped, prev_swapped;

  // One comparator phase applied to q; also flags whether any pair exchanged.
  always_comb begin
    swapped = 1'b0;
    for (int i = 0; i < N; i++) nxt[i] = q[i];
    for (int p = 0; p < N - 1; p++) begin
      if (p[0] == phase_cnt[0]) begin
        if ((ASCENDING != 0) ? gt(q[p], q[p+1]) : gt(q[p+1], q[p])) begin
          nxt[p]   = q[p+1];
          nxt[p+1] = q[p];
          swapped  = 1'b1;
        end
      end
    end
  end

  // Two back-to-back swap-free phases (one even, one odd) mean the vector is already ordered.
  assign last = (phase_cnt == '1) || (!swapped && !prev_swapped && (phase_cnt != '0));

  // Swap history of the previous phase; seeded to 1 so a single quiet phase never ends the sort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    prev_swapped <= 1'b1;
    else if (load) prev_swapped <= 1'b1;
    else if (step) prev_swapped <= swapped;
  end
`else
  // One comparator phase applied to q: even phase pairs (0,1),(2,3)...; odd phase pairs (1,2),(3,4)...
  always_comb begin
    for (int i = 0; i < N; i++) nxt[i] = q[i];
    for (int p = 0; p < N - 1; p++) begin
      if (p[0] == phase_cnt[0]) begin
        if ((ASCENDING != 0) ? gt(q[p], q[p+1]) : gt(q[p+1], q[p])) begin
          nxt[p]   = q[p+1];
          nxt[p+1] = q[p];
        end
      end
    end
  end

  assign last = (phase_cnt == '1);
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake decode; a DONE handshake can chain straight into a new load.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load      = 1'b1;
          state_nxt = SORT;
        end
      end
      SORT: begin
        step = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) begin
          in_ready = 1'b1;
          if (in_valid) begin
            load      = 1'b1;
            state_nxt = SORT;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Vector and phase counter; counter saturates at the final phase instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) q[i] <= '0;
      phase_cnt <= '0;
    end else if (load) begin
      for (int i = 0; i < N; i++) q[i] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
      phase_cnt <= '0;
    end else if (step) begin
      for (int i = 0; i < N; i++) q[i] <= nxt[i];
      if (!last) phase_cnt <= phase_cnt + 1'b1;
    end
  end

  // Flatten q onto the output bus, word 0 in the low bits.
  always_comb begin
    for (int i = 0; i < N; i++) out_data[i*DATA_WIDTH +: DATA_WIDTH] = q[i];
  end

  assign out_valid = (state == DONE);
  assign busy      = (state == SORT);

endmodule
